// File: rtl/nand_logic_pkg.sv
// Shared definitions for the NAND-built logic pipeline: op-select encoding used by RTL and bench.
package nand_logic_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_NOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NAND = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/nand_logic_slice.sv
// One-bit op evaluator: all eight functions and the 8:1 select tree are built from 2-input NAND cells.
module nand_logic_slice
    import nand_logic_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] sel,
    output logic       y
);

    wire       n_a, n_b, n_ab, x_t1, x_t2;
    wire       f_or, f_xor;
    wire [7:0] op_v;
    wire [2:0] n_sel;
    wire [3:0] lvl1;
    wire [1:0] lvl2;
    wire       y_w;

    nand u_na   (n_a, a, a);
    nand u_nb   (n_b, b, b);
    nand u_nab  (n_ab, a, b);
    nand u_or   (f_or, n_a, n_b);
    nand u_x1   (x_t1, a, n_ab);
    nand u_x2   (x_t2, b, n_ab);
    nand u_xor  (f_xor, x_t1, x_t2);

    nand u_f_not  (op_v[OP_NOT],  a, a);
    nand u_f_nor  (op_v[OP_NOR],  f_or, f_or);
    nand u_f_and  (op_v[OP_AND],  n_ab, n_ab);
    nand u_f_or   (op_v[OP_OR],   n_a, n_b);
    nand u_f_xor  (op_v[OP_XOR],  x_t1, x_t2);
    nand u_f_xnor (op_v[OP_XNOR], f_xor, f_xor);
    nand u_f_nand (op_v[OP_NAND], a, b);
    nand u_f_pass (op_v[OP_PASS], n_a, n_a);

    for (genvar k = 0; k < 3; k++) begin : g_nsel
        nand u_ns (n_sel[k], sel[k], sel[k]);
    end

    // Each 2:1 mux is nand(nand(d0, ~s), nand(d1, s)).
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        wire p0, p1;
        nand u_p0 (p0, op_v[2*i], n_sel[0]);
        nand u_p1 (p1, op_v[2*i+1], sel[0]);
        nand u_m  (lvl1[i], p0, p1);
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl2
        wire p0, p1;
        nand u_p0 (p0, lvl1[2*i], n_sel[1]);
        nand u_p1 (p1, lvl1[2*i+1], sel[1]);
        nand u_m  (lvl2[i], p0, p1);
    end

    wire q0, q1;
    nand u_q0  (q0, lvl2[0], n_sel[2]);
    nand u_q1  (q1, lvl2[1], sel[2]);
    nand u_out (y_w, q0, q1);

    assign y = y_w;

endmodule

// File: rtl/nand_logic_pipe.sv
// WIDTH-bit NAND-built logic unit with a 2-stage valid/ready pipeline, accumulator operand and flags.
module nand_logic_pipe
    import nand_logic_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc_q
);

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;
    logic             s1_load;
    logic             s2_load;
    logic             accept;
    wire  [WIDTH-1:0] result;
    wire              s1_zero;

    assign op_b     = in_acc ? acc_q : in_b;
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        nand_logic_slice u_slice (
            .a   (in_a[i]),
            .b   (op_b[i]),
            .sel (in_sel),
            .y   (result[i])
        );
    end

    // Flags are precomputed on s1_data so they land in S2 on the same edge as the data.
    for (genvar i = 0; i < WIDTH; i++) begin : g_red
        wire or_o, par_o;
        if (i == 0) begin : g_base
            assign or_o  = s1_data[0];
            assign par_o = s1_data[0];
        end else begin : g_link
            wire n_or, n_d, n_pd, p_t1, p_t2;
            nand u_no (n_or, g_red[i-1].or_o, g_red[i-1].or_o);
            nand u_nd (n_d, s1_data[i], s1_data[i]);
            nand u_or (or_o, n_or, n_d);
            nand u_pd (n_pd, g_red[i-1].par_o, s1_data[i]);
            nand u_p1 (p_t1, g_red[i-1].par_o, n_pd);
            nand u_p2 (p_t2, s1_data[i], n_pd);
            nand u_px (par_o, p_t1, p_t2);
        end
    end

    nand u_zero (s1_zero, g_red[WIDTH-1].or_o, g_red[WIDTH-1].or_o);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so S1 and S2 shift cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) s1_data <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= s1_data;
                out_zero   <= s1_zero;
                out_parity <= g_red[WIDTH-1].par_o;
            end
        end
    end

    // Clear beats update; an op accepted alongside a clear has already used the old value as B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= ACC_INIT;
        end else if (acc_clr) begin
            acc_q <= ACC_INIT;
        end else if (accept && in_acc) begin
            acc_q <= result;
        end
    end

endmodule
